// File: rtl/dmem_responder.sv
// Direct-mapped, one-word-per-line, write-through cache responder in front of a fixed-latency backing memory.
// Optional build macro: DMEM_RSP_WRITE_ALLOC_EN (write misses allocate the line).
module dmem_responder #(
    parameter int IDX_W   = 3,
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 15 - IDX_W;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

`ifdef DMEM_RSP_WRITE_ALLOC_EN
    localparam logic WRITE_ALLOC = 1'b1;
`else
    localparam logic WRITE_ALLOC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t             state_reg;
    logic [3:0]         count_reg;
    logic [14:0]        addr_reg;
    logic [15:0]        data_reg;
    logic               hit_reg;
    logic [15:0]        data_out_reg;
    logic [15:0]        rd_data_reg;

    logic               valid_reg [LINES];
    logic [TAG_W-1:0]   tag_mem   [LINES];
    logic [15:0]        line_mem  [LINES];
    logic [15:0]        backing   [32768];

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic [14:0]        mem_raddr;
    logic               idle;
    logic               legal_rd;
    logic               legal_wr;
    logic               lookup_hit;
    logic               rd_hit;
    logic               fill_done;
    logic               wr_done;
    logic               line_wr;

    assign req_idx    = Addr[IDX_W:1];
    assign req_tag    = Addr[15:IDX_W+1];
    assign lat_idx    = addr_reg[IDX_W-1:0];
    assign lat_tag    = addr_reg[14:IDX_W];

    // Outputs are suppressed during reset so an in-flight completion never escapes.
    assign idle       = (state_reg == IDLE) && !rst;
    assign legal_rd   = idle && Rd && !Wr && !Addr[0];
    assign legal_wr   = idle && Wr && !Rd && !Addr[0];
    assign lookup_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd_hit     = legal_rd && lookup_hit;
    assign fill_done  = (state_reg == RD_MISS) && (count_reg == 4'd0) && !rst;
    assign wr_done    = (state_reg == WR_THRU) && (count_reg == 4'd0) && !rst;
    assign line_wr    = fill_done || (wr_done && (hit_reg || WRITE_ALLOC));

    assign err        = idle && (Rd || Wr) && ((Rd && Wr) || Addr[0]);
    assign Stall      = (state_reg != IDLE);
    assign Done       = rd_hit || fill_done || wr_done;
    assign CacheHit   = rd_hit || (wr_done && hit_reg);

    always_comb begin
        DataOut = data_out_reg;
        if (rd_hit)
            DataOut = line_mem[req_idx];
        else if (fill_done)
            DataOut = rd_data_reg;
    end

    // The backing read address is the live request in IDLE and the latched one afterwards,
    // so the registered read is ready well before the fill cycle.
    assign mem_raddr = (state_reg == IDLE) ? Addr[15:1] : addr_reg;

    always_ff @(posedge clk) begin
        if (wr_done)
            backing[addr_reg] <= data_reg;
        rd_data_reg <= backing[mem_raddr];
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[lat_idx]  <= lat_tag;
            line_mem[lat_idx] <= rd_data_reg;
        end else if (line_wr) begin
            tag_mem[lat_idx]  <= lat_tag;
            line_mem[lat_idx] <= data_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst)
                    valid_reg[gi] <= 1'b0;
                else if (line_wr && (lat_idx == IDX_W'(gi)))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= 4'd0;
            addr_reg     <= 15'd0;
            data_reg     <= 16'd0;
            hit_reg      <= 1'b0;
            data_out_reg <= 16'd0;
        end else begin
            if (Done)
                data_out_reg <= DataOut;
            case (state_reg)
                IDLE: begin
                    if (legal_rd && !lookup_hit) begin
                        state_reg <= RD_MISS;
                        count_reg <= LAT_INIT;
                        addr_reg  <= Addr[15:1];
                    end else if (legal_wr) begin
                        state_reg <= WR_THRU;
                        count_reg <= LAT_INIT;
                        addr_reg  <= Addr[15:1];
                        data_reg  <= DataIn;
                        hit_reg   <= lookup_hit;
                    end
                end
                RD_MISS, WR_THRU: begin
                    if (count_reg == 4'd0)
                        state_reg <= IDLE;
                    else
                        count_reg <= count_reg - 4'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expectations queued at request time, checked at completion.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = 16'h0;
    logic [15:0] DataIn = 16'h0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] data;
        logic        hit;
        int          lat;
        logic        is_rd;
        string       name;
    } exp_t;

    exp_t sb[$];

    dmem_responder dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
        end
    endtask

    // Drives one request and follows it to Done, scrambling inputs while stalled.
    task automatic req(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din,
                       input logic [15:0] edata, input logic ehit, input int elat, input string name);
        exp_t e;
        int cyc;
        e.data = edata; e.hit = ehit; e.lat = elat; e.is_rd = rd; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        cyc = 0;
        forever begin
            #1;
            if (Done === 1'b1) break;
            chk({name, "_stall"}, 32'(Stall), 32'(cyc != 0));
            if (cyc > 40) begin
                chk({name, "_timeout"}, 32'(Done), 32'd1);
                break;
            end
            @(negedge clk);
            Rd = wr; Wr = rd; Addr = addr ^ 16'h0200; DataIn = ~din;
            cyc++;
        end
        e = sb.pop_front();
        $display("txn %s rd=%0b addr=%h lat=%0d hit=%0b data=%h", e.name, e.is_rd, addr, cyc, CacheHit, DataOut);
        chk({e.name, "_lat"}, 32'(cyc), 32'(e.lat));
        chk({e.name, "_hit"}, 32'(CacheHit), 32'(e.hit));
        chk({e.name, "_stall_done"}, 32'(Stall), 32'(e.lat != 0));
        if (e.is_rd)
            chk({e.name, "_data"}, 32'(DataOut), 32'(e.data));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        #1;
    endtask

    localparam logic [15:0] MISS5555_DATA = 16'h5555;
`ifdef DMEM_RSP_WRITE_ALLOC_EN
    localparam logic ALLOC_HIT = 1'b1;
    localparam int   ALLOC_LAT = 0;
`else
    localparam logic ALLOC_HIT = 1'b0;
    localparam int   ALLOC_LAT = 4;
`endif

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dataout", 32'(DataOut), 32'h0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_hit", 32'(CacheHit), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Preload backing words through write misses, then clear the cache.
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, 4, "pre_wr10");
        req(1'b0, 1'b1, 16'h0040, 16'h7777, 16'h0, 1'b0, 4, "pre_wr40");
        req(1'b0, 1'b1, 16'h0020, 16'h0C0C, 16'h0, 1'b0, 4, "pre_wr20");
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_dataout", 32'(DataOut), 32'h0);

        req(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 4, "rd_miss");
        req(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b1, 0, "rd_hit");
        req(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0, 1'b1, 4, "wr_hit");
        req(1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b1, 0, "rd_after_wr");
        req(1'b0, 1'b1, 16'h0100, MISS5555_DATA, 16'h0, 1'b0, 4, "wr_miss");
        req(1'b1, 1'b0, 16'h0100, 16'h0, MISS5555_DATA, ALLOC_HIT, ALLOC_LAT, "rd_after_wrmiss");
        req(1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 4, "rd_backing_wt");
        req(1'b1, 1'b0, 16'h0020, 16'h0, 16'h0C0C, 1'b0, 4, "rd_conflict");
        req(1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 4, "rd_evicted");
        req(1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b1, 0, "rd_refill_hit");

        idle_cycle();
        chk("hold_done", 32'(Done), 32'd0);
        chk("hold_dataout", 32'(DataOut), 32'h1234);

        // Illegal requests: flagged in the same cycle, nothing else moves.
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0010;
        #1;
        $display("txn illegal_rdwr err=%0b stall=%0b done=%0b", err, Stall, Done);
        chk("ill_rdwr_err", 32'(err), 32'd1);
        chk("ill_rdwr_stall", 32'(Stall), 32'd0);
        chk("ill_rdwr_done", 32'(Done), 32'd0);
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0011;
        #1;
        $display("txn illegal_odd err=%0b stall=%0b done=%0b", err, Stall, Done);
        chk("ill_odd_err", 32'(err), 32'd1);
        chk("ill_odd_done", 32'(Done), 32'd0);
        idle_cycle();
        chk("ill_after_err", 32'(err), 32'd0);
        chk("ill_after_stall", 32'(Stall), 32'd0);

        // Reset in the middle of a write discards it.
        @(negedge clk);
        Wr = 1'b1; Rd = 1'b0; Addr = 16'h0040; DataIn = 16'hAAAA;
        @(negedge clk);
        Wr = 1'b0;
        #1;
        chk("rstwr_stall", 32'(Stall), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwr_done_in_rst", 32'(Done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("txn rst_mid_write stall=%0b done=%0b", Stall, Done);
        chk("rstwr_idle", 32'(Stall), 32'd0);
        chk("rstwr_no_done", 32'(Done), 32'd0);
        idle_cycle();
        chk("rstwr_no_done2", 32'(Done), 32'd0);
        req(1'b1, 1'b0, 16'h0040, 16'h0, 16'h7777, 1'b0, 4, "rd_after_rstwr");
        req(1'b1, 1'b0, 16'h0040, 16'h0, 16'h7777, 1'b1, 0, "b2b_hit1");
        req(1'b1, 1'b0, 16'h0040, 16'h0, 16'h7777, 1'b1, 0, "b2b_hit2");
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
